// File: rtl/wm_pkg.sv
// Shared types and defaults for the washing-machine scheduler slice.
// Holds the scheduler state encoding and the default sizing constants.
package wm_pkg;

    localparam int N_USERS_DEF = 4;
    localparam int TIMEOUT_DEF = 200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_RUN,
        ST_PAUSED,
        ST_FINISH,
        ST_FAULT
    } wm_state_e;

endpackage

// File: rtl/wm_scheduler_if.sv
// Bundle of user-panel and washing-machine signals around the scheduler.
// master = the scheduler itself, slave = the panel/machine side driving it.
interface wm_scheduler_if #(
    parameter int N_USERS = wm_pkg::N_USERS_DEF
);
    localparam int OW = (N_USERS > 1) ? $clog2(N_USERS) : 1;

    logic [N_USERS-1:0] req;
    logic [N_USERS-1:0] user_pause;
    logic               door_open;
    logic               clear_fault;
    logic               wm_done;
    logic               wm_start;
    logic               wm_pause;
    logic               wm_res;
    logic               busy;
    logic [OW-1:0]      owner;
    logic [N_USERS-1:0] pending;
    logic [N_USERS-1:0] job_done;
    logic [N_USERS-1:0] job_fail;
    logic               fault;

    modport master (
        input  req, user_pause, door_open, clear_fault, wm_done,
        output wm_start, wm_pause, wm_res, busy, owner, pending,
               job_done, job_fail, fault
    );

    modport slave (
        output req, user_pause, door_open, clear_fault, wm_done,
        input  wm_start, wm_pause, wm_res, busy, owner, pending,
               job_done, job_fail, fault
    );

endinterface

// File: rtl/wm_rr_arbiter.sv
// Combinational round-robin pick: first pending user after last_owner,
// wrapping from N_USERS-1 back to 0; last_owner itself is tried last.
module wm_rr_arbiter #(
    parameter int N_USERS = 4,
    parameter int OW      = (N_USERS > 1) ? $clog2(N_USERS) : 1
) (
    input  logic [N_USERS-1:0] pending,
    input  logic [OW-1:0]      last_owner,
    output logic [OW-1:0]      grant_idx,
    output logic               grant_valid
);

    logic [OW-1:0] cand [N_USERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_USERS; gi++) begin : g_cand
            logic [OW:0] sum;
            assign sum       = {1'b0, last_owner} + (OW+1)'(gi + 1);
            assign cand[gi]  = (sum >= (OW+1)'(N_USERS)) ? OW'(sum - (OW+1)'(N_USERS))
                                                          : OW'(sum);
        end
    endgenerate

    // Walk from the farthest candidate inward so the nearest one wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = N_USERS - 1; k >= 0; k--) begin
            if (pending[cand[k]]) begin
                grant_idx   = cand[k];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wm_scheduler.sv
// Shares one washing machine among N_USERS requesters: queues requests,
// grants round-robin, forwards pause, detects completion and hung cycles.
module wm_scheduler
    import wm_pkg::*;
#(
    parameter int N_USERS = N_USERS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           res,
    wm_scheduler_if.master bus
);

    localparam int OW = (N_USERS > 1) ? $clog2(N_USERS) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    wm_state_e          state_q, state_d;
    logic [N_USERS-1:0] pending_q, pending_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q, last_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic               wm_start_q, wm_start_d;
    logic               wm_pause_q, wm_pause_d;
    logic               fault_q, fault_d;
    logic               busy_q, busy_d;
    logic [N_USERS-1:0] job_done_q, job_done_d;
    logic [N_USERS-1:0] job_fail_q, job_fail_d;

    logic [OW-1:0]      grant_idx;
    logic               grant_valid;
    logic [N_USERS-1:0] grant_oh, owner_oh, owner_d_oh;
    logic               pause_req;

    wm_rr_arbiter #(.N_USERS(N_USERS), .OW(OW)) u_arb (
        .pending     (pending_q),
        .last_owner  (last_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_USERS; gi++) begin : g_onehot
            assign grant_oh[gi]   = (grant_idx == OW'(gi));
            assign owner_oh[gi]   = (owner_q   == OW'(gi));
            assign owner_d_oh[gi] = (owner_d   == OW'(gi));
        end
    endgenerate

    assign pause_req = bus.door_open | (|(bus.user_pause & owner_oh));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | bus.req;
        owner_d   = owner_q;
        last_d    = last_q;
        wd_d      = wd_q;
        case (state_q)
            ST_IDLE:   if (|pending_q) state_d = ST_GRANT;
            ST_GRANT: begin
                if (grant_valid) begin
                    owner_d   = grant_idx;
                    last_d    = grant_idx;
                    // A fresh req from the winner in this cycle re-queues it.
                    pending_d = (pending_q & ~grant_oh) | bus.req;
                    state_d   = ST_START;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.wm_done)                  state_d = ST_FINISH;
                else if (pause_req)               state_d = ST_PAUSED;
                else if (wd_q == WW'(TIMEOUT - 1)) state_d = ST_FAULT;
                else                              wd_d    = wd_q + WW'(1);
            end
            ST_PAUSED: begin
                if (bus.wm_done)     state_d = ST_FINISH;
                else if (!pause_req) state_d = ST_RUN;
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_FAULT:  if (bus.clear_fault) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        wm_start_d = (state_d == ST_START);
        wm_pause_d = (state_d == ST_PAUSED);
        fault_d    = (state_d == ST_FAULT);
        busy_d     = (state_d != ST_IDLE);
        job_done_d = (state_d == ST_FINISH) ? owner_d_oh : '0;
        job_fail_d = (state_q == ST_RUN && state_d == ST_FAULT) ? owner_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            owner_q    <= '0;
            last_q     <= OW'(N_USERS - 1);
            wd_q       <= '0;
            wm_start_q <= 1'b0;
            wm_pause_q <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
            job_done_q <= '0;
            job_fail_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            wm_start_q <= wm_start_d;
            wm_pause_q <= wm_pause_d;
            fault_q    <= fault_d;
            busy_q     <= busy_d;
            job_done_q <= job_done_d;
            job_fail_q <= job_fail_d;
        end
    end

    assign bus.wm_start = wm_start_q;
    assign bus.wm_pause = wm_pause_q;
    assign bus.wm_res   = fault_q;
    assign bus.fault    = fault_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.pending  = pending_q;
    assign bus.job_done = job_done_q;
    assign bus.job_fail = job_fail_q;

endmodule

// File: doc/wm_scheduler.md
Name: wm_scheduler

Overview:
- Shares one washing_machine instance among N_USERS requesters.
- Queues wash requests, grants the machine round-robin and issues the start pulse.
- Forwards pause from a door interlock or from the owning user, watches for `done`, and runs a watchdog for hung cycles.
- Sits between the user/panel logic and washing_machine's start/pause/done/res pins.

Parameters:
- N_USERS, 4, number of requesters (2..16)
- TIMEOUT, 200, max un-paused cycles allowed in RUN before fault
- OW, $clog2(N_USERS), owner index width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  synchronous active-high reset
- req  in  N_USERS  per-user wash request pulse; one cycle high sets pending bit
- user_pause  in  N_USERS  per-user pause level; only the owner's bit is honoured
- door_open  in  1  interlock level; forces pause while high
- clear_fault  in  1  one-cycle pulse, leaves FAULT
- wm_done  in  1  done from washing_machine
- wm_start  out  1  one-cycle start pulse to washing_machine
- wm_pause  out  1  pause level to washing_machine
- wm_res  out  1  reset to washing_machine, high throughout FAULT
- busy  out  1  high in every state except IDLE
- owner  out  OW  index of granted user, valid when busy
- pending  out  N_USERS  queued-request vector
- job_done  out  N_USERS  one-cycle pulse on owner's bit at completion
- job_fail  out  N_USERS  one-cycle pulse on owner's bit at watchdog fault
- fault  out  1  high in FAULT

Behaviour:
- Reset (synchronous, priority over all else):
  - state=IDLE; all outputs 0.
  - pending=0, watchdog=0, last owner pointer=N_USERS-1, so user 0 wins first.
- pending capture:
  - pending[i] sets the cycle after req[i]=1.
  - pending[i] clears in the GRANT cycle for the granted user.
  - A req from the current owner while busy re-queues that owner; no effect on the running job.
- States:
  - IDLE: if pending!=0, go to GRANT.
  - GRANT (1 cycle):
    - Round-robin search starting at last_owner+1, wrapping at N_USERS-1 to 0.
    - Register owner and last_owner; clear pending[owner]; go to START.
  - START (1 cycle): wm_start=1, watchdog=0; go to RUN.
  - RUN:
    - wm_done=1 goes to FINISH. This takes precedence over pause and timeout in the same cycle.
    - Otherwise, door_open or user_pause[owner] goes to PAUSED.
    - Otherwise, watchdog increments. When watchdog==TIMEOUT-1 while still in RUN, go to FAULT.
  - PAUSED:
    - wm_pause=1; watchdog frozen.
    - wm_done=1 goes to FINISH.
    - Return to RUN the cycle after door_open and user_pause[owner] are both 0.
  - FINISH (1 cycle): job_done[owner]=1; go to IDLE; the next grant is evaluated from IDLE.
  - FAULT:
    - job_fail[owner] pulses on entry cycle only; fault=1 and wm_res=1 throughout.
    - clear_fault goes to IDLE; pending requests from other users are preserved.
- Latency:
  - req pulse to wm_start: 3 cycles from idle (capture, GRANT, START).
  - Hung job: fault asserted exactly TIMEOUT un-paused RUN cycles after START.
- All outputs are registered. wm_start, job_done and job_fail are never high for two consecutive cycles.
- user_pause bits of non-owners are ignored. door_open in IDLE or GRANT has no effect, and START still issues.
- Reset mid-RUN or mid-PAUSED drops the job silently: no job_done or job_fail pulse.

Decomposition:
- Shared package wm_pkg:
  - state enum (IDLE, GRANT, START, RUN, PAUSED, FINISH, FAULT);
  - default TIMEOUT and N_USERS constants.
- One sub-module, wm_rr_arbiter: combinational round-robin pick.
  - Inputs: pending vector and last-owner pointer.
  - Outputs: grant index and grant-valid.
  - Unit-testable alone.

Test Plan:
- Reset, then req[2] pulse at cycle 0 → wm_start high at cycle 3, owner=2; wm_done at cycle 20 → job_done=4'b0100 one cycle later, busy=0 after.
- req=4'b1011 in one cycle → grants in order 0,1,3. After owner 3 finishes, req[0] then wins next; pending shrinks 1011→1010→1000→0000.
- During RUN, door_open high for 5 cycles → wm_pause high 5 cycles, watchdog frozen; user_pause[1] while owner=0 → no pause.
- TIMEOUT=50, never assert wm_done → fault=1, wm_res=1 at cycle 50 after START, job_fail[owner] one-cycle pulse. clear_fault → IDLE, then a queued req[3] is granted.
- wm_done and door_open rising together in RUN → FINISH, job_done pulses, wm_pause stays 0.
- res asserted mid-RUN with pending=4'b0110 → next cycle all outputs 0, pending=0, no job_done/job_fail. Next req[3] → owner=3.
